// File: rtl/tristate_line_rx_pkg.sv
// Shared types and defaults for the shared-line receiver and its helpers.
package tristate_line_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_PARITY_EN    = 0;
  localparam int DEF_HALF_BIT     = DEF_CLKS_PER_BIT / 2 - 1;

  // Counter value at the middle of the start bit.
  function automatic int half_bit(input int cpb);
    return cpb / 2 - 1;
  endfunction

endpackage

// File: rtl/tristate_line_rx_if.sv
// Receiver-side bundle: resolved line, echo enable, byte handoff and status pulses.
interface tristate_line_rx_if
  import tristate_line_rx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              line_in;
  logic              en;
  logic              rx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              frame_err;
  logic              parity_err;
  logic              overrun;
  logic              busy;

  modport master (
    input  line_in, en, rx_ready,
    output rx_data, rx_valid, frame_err, parity_err, overrun, busy
  );

  modport slave (
    output line_in, en, rx_ready,
    input  rx_data, rx_valid, frame_err, parity_err, overrun, busy
  );

endinterface

// File: rtl/tristate_line_rx_line_sync.sv
// Two-flop synchronizer that idles high, matching a pulled-up line.
module tristate_line_rx_line_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_ff;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_ff <= 2'b11;
    else       r_ff <= {r_ff[0], i_d};
  end

  assign o_q = r_ff[1];

endmodule

// File: rtl/tristate_line_rx.sv
// Oversampling frame receiver for the shared tristate line with a valid/ready
// holding register; ignores the line while this node is driving it.
module tristate_line_rx
  import tristate_line_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int PARITY_EN    = DEF_PARITY_EN
) (
  input  logic               clk,
  input  logic               rst,
  tristate_line_rx_if.master bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] HALF     = CW'(half_bit(CLKS_PER_BIT));
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  state_e            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [IW-1:0]     r_idx;
  logic [DATA_W-1:0] r_shift;
  logic              r_par_bad;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid, r_frame_err, r_parity_err, r_overrun;

  logic w_line_s, w_half, w_bit;
  logic w_busy, w_data_pt, w_par_pt, w_stop_pt, w_done, w_ferr, w_perr;

  tristate_line_rx_line_sync u_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (bus.line_in),
    .o_q   (w_line_s)
  );

  assign w_half = (r_cnt == HALF);
  assign w_bit  = (r_cnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (r_state != S_IDLE && bus.en) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:      if (!w_line_s && !bus.en) w_next = S_START;
        S_START:     if (w_half) w_next = w_line_s ? S_IDLE : S_DATA;
        S_DATA:      if (w_bit && r_idx == LAST_IDX)
                       w_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        S_PARITY:    if (w_bit) w_next = S_STOP;
        S_STOP:      if (w_bit) w_next = w_line_s ? S_IDLE : S_WAIT_HIGH;
        S_WAIT_HIGH: if (w_line_s) w_next = S_IDLE;
        default:     w_next = S_IDLE;
      endcase
    end
  end

  // Sample strobes are masked by en so an abort cycle never reports anything.
  always_comb begin
    w_busy    = (r_state != S_IDLE);
    w_data_pt = (r_state == S_DATA)   && w_bit && !bus.en;
    w_par_pt  = (r_state == S_PARITY) && w_bit && !bus.en;
    w_stop_pt = (r_state == S_STOP)   && w_bit && !bus.en;
    w_ferr    = w_stop_pt && !w_line_s;
    w_perr    = w_stop_pt &&  w_line_s &&  r_par_bad;
    w_done    = w_stop_pt &&  w_line_s && !r_par_bad;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_par_bad <= 1'b0;
    end else begin
      if (r_state == S_IDLE || w_next != r_state || w_bit) r_cnt <= '0;
      else                                                 r_cnt <= r_cnt + 1'b1;

      if (w_next == S_START) begin
        r_idx     <= '0;
        r_par_bad <= 1'b0;
      end else if (w_data_pt) begin
        r_shift[r_idx] <= w_line_s;
        r_idx          <= r_idx + 1'b1;
      end

      if (w_par_pt) r_par_bad <= (^r_shift) ^ w_line_s;
    end
  end

  // A completing frame wins over a same-cycle drain; otherwise the old byte stays.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_err  <= w_ferr;
      r_parity_err <= w_perr;
      r_overrun    <= w_done && r_rx_valid && !bus.rx_ready;
      if (w_done && (!r_rx_valid || bus.rx_ready)) begin
        r_rx_data  <= r_shift;
        r_rx_valid <= 1'b1;
      end else if (bus.rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign bus.rx_data    = r_rx_data;
  assign bus.rx_valid   = r_rx_valid;
  assign bus.frame_err  = r_frame_err;
  assign bus.parity_err = r_parity_err;
  assign bus.overrun    = r_overrun;
  assign bus.busy       = w_busy;

endmodule

// File: doc/tristate_line_rx.md
Name: tristate_line_rx

Overview:
- Receive end of the team's single-wire, half-duplex shared line.
- Drivers put frames onto the line through tristate buffers; a pull-up holds the line high when idle.
- This block oversamples the resolved line, decodes start/data/parity/stop framing, and hands each byte to local logic through a valid/ready holding register.
- It suppresses its own transmissions using the local driver enable.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per bit period; must be even and >= 4.
- DATA_W, 8: data bits per frame, sent LSB first.
- PARITY_EN, 0: 1 means an even-parity bit follows the data bits.

Ports:
- clk  input  1  single system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- line_in  input  1  resolved shared line level (pull-up included); asynchronous to clk.
- en  input  1  local tristate driver enable; high means this node is driving the line.
- rx_data  output  DATA_W  received byte; stable while rx_valid is high.
- rx_valid  output  1  holding register full.
- rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- parity_err  output  1  one-cycle pulse: parity mismatch (PARITY_EN=1 only).
- overrun  output  1  one-cycle pulse: good frame lost because the holding register was full.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset state:
  - Synchronizer flops = 1; FSM = IDLE; counters = 0.
  - rx_data = 0; rx_valid = 0; all error pulses = 0; busy = 0.
  - Reset asserted mid-frame abandons the frame immediately; no output or error is produced.
- Input sync: line_in passes through 2 flops; line_s is the second flop. All decisions use line_s.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH. A bit counter (0..CLKS_PER_BIT-1) and a bit index (0..DATA_W-1) drive the transitions.
- IDLE:
  - line_s==0 and en==0 -> START, counter cleared.
  - line_s low while en==1 is ignored (echo suppression).
- START:
  - At counter == CLKS_PER_BIT/2-1, sample line_s.
  - Sample 1 -> glitch; return to IDLE with no flags.
  - Sample 0 -> DATA, counter cleared, bit index = 0.
- DATA:
  - Sample every CLKS_PER_BIT cycles (counter == CLKS_PER_BIT-1).
  - Shift each sample into bit position [index], LSB first.
  - After bit DATA_W-1 -> PARITY if PARITY_EN, else STOP.
- PARITY: sample one bit; the parity error flag is latched when XOR(data bits, parity bit) != 0. Then -> STOP.
- STOP: sample one bit, then:
  - Sample 0 -> frame_err pulse, data discarded, -> WAIT_HIGH.
  - Sample 1 with parity bad -> parity_err pulse, data discarded, -> IDLE.
  - Sample 1 with parity good -> frame complete, -> IDLE.
- WAIT_HIGH: remain until line_s==1, then IDLE. A held-low or break line never produces repeated errors.
- en abort: en rising to 1 in any state other than IDLE -> IDLE next cycle; partial frame discarded; no flags raised.
- Holding register and latency:
  - On frame complete, rx_data/rx_valid update on the clock edge after the stop-bit sample cycle.
  - Handoff latency from the stop-bit sample point is 1 cycle.
- rx_valid stays high until a cycle with rx_ready==1; the register clears that cycle unless a new frame completes in the same cycle.
- Simultaneous completion and rx_ready==1: the new byte is loaded; rx_valid stays 1; no overrun.
- Completion while rx_valid==1 and rx_ready==0: overrun pulse; the old byte is kept and the new byte dropped.
- Error pulses are exactly one cycle wide and mutually exclusive per frame.
- Back-to-back frames: a start edge immediately after the stop-bit sample point is accepted; no extra idle cycle is required.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH).
  - Default-parameter constants.
  - Half-bit constant (CLKS_PER_BIT/2-1).
- One sub-module is natural: line_sync, a 2-flop synchronizer with async-high reset to 1. It is reusable for the transmit-side collision monitor.
- The FSM, counters and holding register stay in this module.

Test Plan:
1. Defaults; drive byte 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) with rx_ready=1 -> rx_valid one cycle, rx_data=0xA5; no flags; busy falls after stop.
2. 4-cycle low glitch on line_in while idle -> START aborts at half-bit; no rx_valid, no flags, busy back to 0.
3. Frame 0x3C with stop bit 0, then line held low 40 cycles -> one frame_err pulse only; FSM waits in WAIT_HIGH; next good frame 0x01 is received correctly.
4. PARITY_EN=1, frame 0x07 with parity bit 0 -> parity_err pulse, no rx_valid; same frame with parity 1 -> rx_data=0x07.
5. rx_ready=0; send 0x11 then 0x22 back to back -> rx_data stays 0x11, overrun pulses once at the 0x22 completion. Second sub-case: rx_ready=1 in exactly the 0x22 completion cycle -> rx_data=0x22, no overrun.
6. Drive 0x55 with en=1 throughout -> no reception. Raise en midway through a frame -> abort to IDLE, no flags. Assert rst mid-frame -> all outputs return to reset values asynchronously.
